// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding shared by the serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: gate-level single-bit subtractor cell, Dout = A ^ B ^ Bin
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Dout,
  output logic Bout
);
  logic t, na, nt, p, q;
  xor g0 (t, A, B);
  xor g1 (Dout, t, Bin);
  not g2 (na, A);
  not g3 (nt, t);
  and g4 (p, na, B);
  and g5 (q, nt, Bin);
  or  g6 (Bout, p, q);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - BIN, LSB first, one bit per clock
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CNT_W-1:0] cnt;
  logic br, d_bit, br_n, accept, last;
  full_subtractor u_cell (.Dout(d_bit), .Bout(br_n), .A(sa[0]), .B(sb[0]), .Bin(br));
  assign accept = (state == IDLE || state == DONE) && start;
  assign last = state == RUN && cnt == CNT_W'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  // anything that is neither an accept nor an active run, including 2'd3, falls to IDLE
  always_comb state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
      D <= '0;
      BOUT <= 1'b0;
    end else if (accept) begin
      sa <= A;
      sb <= B;
      br <= BIN;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      res <= {d_bit, res[WIDTH-1:1]};
      br <= br_n;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        D <= {d_bit, res[WIDTH-1:1]};
        BOUT <= br_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of two widths against a timeline model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic st[2];
  logic [7:0] av[2], bv[2];
  logic bi[2];
  logic busy0, done0, bout0, busy1, done1, bout1;
  logic [7:0] d0;
  logic [4:0] d1;
  int checks = 0, errors = 0;
  int dc[2] = '{0, 0};
  int acc[2] = '{0, 0};
  int left[2] = '{0, 0};
  logic m_busy[2], m_done[2], m_bout[2], pb[2];
  logic [7:0] m_d[2], pd[2];

  serial_subtractor #(.WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .A(av[0]), .B(bv[0]), .BIN(bi[0]),
    .busy(busy0), .done(done0), .D(d0), .BOUT(bout0)
  );
  serial_subtractor #(.WIDTH(5)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .A(av[1][4:0]), .B(bv[1][4:0]), .BIN(bi[1]),
    .busy(busy1), .done(done1), .D(d1), .BOUT(bout1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // model: an accepted start publishes the unsigned difference exactly W edges later
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int w, mask, diff;
      w = i == 0 ? 8 : 5;
      mask = (1 << w) - 1;
      if (rst) begin
        left[i] = 0;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_d[i] = 8'h00;
        m_bout[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_d[i] = pd[i];
            m_bout[i] = pb[i];
          end
        end else if (st[i]) begin
          diff = (int'(av[i]) & mask) - (int'(bv[i]) & mask) - int'(bi[i]);
          pd[i] = 8'(diff & mask);
          pb[i] = diff < 0;
          left[i] = w;
          m_busy[i] = 1'b1;
          acc[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy0", 32'(busy0), 32'(m_busy[0]));
    chk("done0", 32'(done0), 32'(m_done[0]));
    chk("d0", 32'(d0), 32'(m_d[0]));
    chk("bout0", 32'(bout0), 32'(m_bout[0]));
    chk("busy1", 32'(busy1), 32'(m_busy[1]));
    chk("done1", 32'(done1), 32'(m_done[1]));
    chk("d1", 32'(d1), 32'(m_d[1]));
    chk("bout1", 32'(bout1), 32'(m_bout[1]));
    if (done0) dc[0]++;
    if (done1) dc[1]++;
  end

  task automatic wait_done0(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done0 && n < 40);
    chk("done_timeout", 32'(done0), 32'd1);
  endtask

  task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] ed, input logic eb);
    int n;
    @(negedge clk);
    av[0] = a; bv[0] = b; bi[0] = c; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done0(n);
    chk("latency", 32'(n), 32'd8);
    chk("lit_d", 32'(d0), 32'(ed));
    chk("lit_bout", 32'(bout0), 32'(eb));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, snap, s0, s1, a0, a1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; av[i] = 8'h00; bv[i] = 8'h00; bi[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_d", 32'(d0), 32'd0);
    run0(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run0(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run0(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run0(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    run0(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
    // start while busy must be ignored
    @(negedge clk); #1;
    snap = dc[0];
    av[0] = 8'h10; bv[0] = 8'h01; bi[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    av[0] = 8'h00; bv[0] = 8'h55;
    repeat (3) @(negedge clk);
    st[0] = 1'b0;
    wait_done0(n);
    chk("ign_d", 32'(d0), 32'h0F);
    chk("ign_bout", 32'(bout0), 32'd0);
    repeat (15) @(negedge clk); #1;
    chk("ign_pulses", 32'(dc[0] - snap), 32'd1);
    // reset in the middle of a run
    @(negedge clk);
    av[0] = 8'h80; bv[0] = 8'h01; bi[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_d", 32'(d0), 32'd0);
    chk("abort_bout", 32'(bout0), 32'd0);
    #1 snap = dc[0];
    repeat (15) @(negedge clk); #1;
    chk("abort_pulses", 32'(dc[0] - snap), 32'd0);
    run0(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    // back-to-back with start held high
    @(negedge clk);
    av[0] = 8'h20; bv[0] = 8'h08; bi[0] = 1'b0; st[0] = 1'b1;
    wait_done0(n);
    chk("b2b_d1", 32'(d0), 32'h18);
    chk("b2b_bout1", 32'(bout0), 32'd0);
    av[0] = 8'h08; bv[0] = 8'h20;
    wait_done0(n);
    st[0] = 1'b0;
    chk("b2b_gap", 32'(n), 32'd9);
    chk("b2b_d2", 32'(d0), 32'hE8);
    chk("b2b_bout2", 32'(bout0), 32'd1);
    repeat (12) @(negedge clk); #1;
    s0 = dc[0]; s1 = dc[1]; a0 = acc[0]; a1 = acc[1];
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st[i] = $urandom_range(0, 3) != 0;
        av[i] = 8'($urandom);
        bv[i] = 8'($urandom);
        bi[i] = 1'($urandom);
      end
    end
    @(negedge clk);
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (20) @(negedge clk); #1;
    chk("rand_count0", 32'(dc[0] - s0), 32'(acc[0] - a0));
    chk("rand_count1", 32'(dc[1] - s1), 32'(acc[1] - a1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
